// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: diff = a - b - bin, one 4-bit lookahead slice per cycle.
// Optional OVERFLOW_FLAG_EN adds the ovf port (two's-complement overflow).
module nibble_serial_subtractor #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   bin,
   output logic [4*NIBBLES-1:0]   diff,
   output logic                   bout,
   output logic                   busy,
   output logic                   done
`ifdef OVERFLOW_FLAG_EN
   ,
   output logic                   ovf
`endif
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            c_q;
   logic [IW-1:0]   idx;

   logic [3:0]      sa;
   logic [3:0]      sb;
   logic [3:0]      g;
   logic [3:0]      p;
   logic [4:0]      c;
   logic [3:0]      s;

   // Borrow lookahead: every carry is a flat sum of products of g, p and c_q.
   always_comb begin
      sa   = a_q[4*idx +: 4];
      sb   = b_q[4*idx +: 4];
      g    = ~sa & sb;
      p    = ~(sa ^ sb);
      c[0] = c_q;
      c[1] = g[0]
           | (p[0] & c_q);
      c[2] = g[1]
           | (p[1] & g[0])
           | (p[1] & p[0] & c_q);
      c[3] = g[2]
           | (p[2] & g[1])
           | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c_q);
      c[4] = g[3]
           | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c_q);
      s    = sa ^ sb ^ c[3:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= 1'b0;
         idx   <= '0;
         diff  <= '0;
         bout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
         ovf   <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q   <= a;
                  b_q   <= b;
                  c_q   <= bin;
                  idx   <= '0;
                  diff  <= '0;
`ifdef OVERFLOW_FLAG_EN
                  ovf   <= 1'b0;
`endif
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               diff[4*idx +: 4] <= s;
               c_q <= c[4];
               idx <= idx + 1'b1;
               if (idx == LAST) begin
                  bout  <= c[4];
`ifdef OVERFLOW_FLAG_EN
                  ovf   <= (a_q[W-1] ^ b_q[W-1])
                         & (s[3] ^ a_q[W-1]);
`endif
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor: latency, results, start
// handling, reset abort and a short model-checked operand sweep.
module tb_nibble_serial_subtractor;

   localparam int W = 16;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          bin;
   logic [W-1:0]  diff;
   logic          bout;
   logic          busy;
   logic          done;
`ifdef OVERFLOW_FLAG_EN
   logic          ovf;
`endif

   int errs;
   int checks;

   nibble_serial_subtractor #(.NIBBLES(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .diff  (diff),
      .bout  (bout),
      .busy  (busy),
      .done  (done)
`ifdef OVERFLOW_FLAG_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One full operation; operands are scrambled right after acceptance.
   task automatic op(input string tag,
                     input logic [W-1:0] ta,
                     input logic [W-1:0] tb,
                     input logic tbin,
                     input logic [W-1:0] ed,
                     input logic eb,
                     input logic eo);
      int n;
      @(negedge clk);
      a = ta;
      b = tb;
      bin = tbin;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = ~ta;
      b = ta ^ tb;
      bin = ~tbin;
      check({tag, ".busy"}, {31'd0, busy}, 32'd1);
      n = 1;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".lat"}, n, 32'd5);
      check({tag, ".diff"}, {16'd0, diff}, {16'd0, ed});
      check({tag, ".bout"}, {31'd0, bout}, {31'd0, eb});
`ifdef OVERFLOW_FLAG_EN
      check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
      if (eo === 1'bx) $display("note: x ovf");
`endif
      @(negedge clk);
      check({tag, ".pulse"}, {31'd0, done}, 32'd0);
      check({tag, ".idle"}, {31'd0, busy}, 32'd0);
      check({tag, ".hold"}, {15'd0, bout, diff}, {15'd0, eb, ed});
   endtask

   initial begin
      logic [16:0] m;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         mo;
      logic [W-1:0] d1;
      logic [W-1:0] d2;
      int           nd;
      int           n;

      errs = 0;
      checks = 0;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      bin = 1'b0;
      repeat (2) @(negedge clk);
      check("rst.diff", {16'd0, diff}, 32'd0);
      check("rst.bout", {31'd0, bout}, 32'd0);
      check("rst.busy", {31'd0, busy}, 32'd0);
      check("rst.done", {31'd0, done}, 32'd0);
      rst = 1'b0;

      op("v1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
      op("v2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      op("v3", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      op("v4", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
      op("v5", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
      op("v6", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      op("v7", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
      op("v8", 16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      op("v9", 16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1);

      // start held for 10 edges with moving operands
      @(negedge clk);
      a = 16'h1234;
      b = 16'h0234;
      bin = 1'b0;
      start = 1'b1;
      nd = 0;
      d1 = '0;
      d2 = '0;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         if (i == 5) check("hold.idle", {31'd0, busy}, 32'd0);
         if (done) begin
            nd++;
            if (nd == 1) d1 = diff;
            if (nd == 2) d2 = diff;
         end
         a = 16'h1234 + 16'(i + 1) * 16'h0111;
         b = 16'h0234 + 16'(i + 1) * 16'h0011;
         if (i == 9) start = 1'b0;
      end
      check("hold.ndone", nd, 32'd2);
      check("hold.d1", {16'd0, d1}, 32'h1000);
      check("hold.d2", {16'd0, d2}, 32'h1600);

      // reset in the second RUN cycle aborts the operation
      @(negedge clk);
      a = 16'h4444;
      b = 16'h1111;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort.busy", {31'd0, busy}, 32'd0);
      check("abort.diff", {16'd0, diff}, 32'd0);
      check("abort.done", {31'd0, done}, 32'd0);
      n = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) n++;
      end
      check("abort.nodone", n, 32'd0);
      op("post", 16'h4444, 16'h1111, 1'b0, 16'h3333, 1'b0, 1'b0);

      // reset wins over start
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      check("prio.busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 200; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         if (i == 0) begin
            ra = 16'h0000;
            rb = 16'hFFFF;
            rc = 1'b1;
         end
         m = {1'b0, ra} - {1'b0, rb} - {16'd0, rc};
         mo = (ra[15] ^ rb[15]) & (m[15] ^ ra[15]);
         op("rnd", ra, rb, rc, m[15:0], m[16], mo);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
